// File: rtl/minas_pkg.sv
// minas_pkg: shared grid constants, engine states and cell indexing for the reveal engine
package minas_pkg;

    localparam int GRID  = 8;
    localparam int CELLS = GRID * GRID;
    localparam int CNT_W = 4;
    localparam int IDX_W = $clog2(CELLS);

    typedef enum logic [2:0] {IDLE, LOAD, READY, SWEEP, LOST, WON} state_t;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
        return IDX_W'(y) * IDX_W'(GRID) + IDX_W'(x);
    endfunction

endpackage

// File: rtl/neighbor_scan.sv
// neighbor_scan: combinational in-bounds 8-neighbour mask of cell idx, gated by map
// Ports: map (per-cell input bits), idx (centre cell), nbr (map bits of the in-bounds neighbours, no wrap)
module neighbor_scan
    import minas_pkg::*;
(
    input  logic [CELLS-1:0] map,
    input  logic [IDX_W-1:0] idx,
    output logic [CELLS-1:0] nbr
);

    function automatic logic near(input logic [2:0] a, input logic [2:0] b);
        return ({1'b0, a} == {1'b0, b}) || ({1'b0, a} == {1'b0, b} + 4'd1) || ({1'b0, b} == {1'b0, a} + 4'd1);
    endfunction

    for (genvar j = 0; j < CELLS; j++) begin : g_cell
        localparam logic [2:0] XJ = 3'(j % GRID);
        localparam logic [2:0] YJ = 3'(j / GRID);
        assign nbr[j] = map[j] && (idx != IDX_W'(j)) && near(XJ, idx[2:0]) && near(YJ, idx[5:3]);
    end

endmodule

// File: rtl/cell_reveal_engine.sv
// cell_reveal_engine: minesweeper game state with neighbour counts, flood reveal, flags and win/loss
// Ports: clk/reset (sync, active-high); board_load + cell_matrix start a game;
//        sel_x/sel_y + reveal_req/flag_req act on the selected cell; q_x/q_y query a cell
//        combinationally (q_revealed, q_flagged, q_bomb, q_count); revealed_map, flag_map,
//        revealed_total, busy, game_over, game_won report game state.
// Build option: REVEAL_BOMBS_ON_LOSS_EN exposes every bomb when one detonates.
module cell_reveal_engine
    import minas_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             board_load,
    input  logic [63:0]      cell_matrix,
    input  logic [3:0]       sel_x,
    input  logic [3:0]       sel_y,
    input  logic             reveal_req,
    input  logic             flag_req,
    input  logic [2:0]       q_x,
    input  logic [2:0]       q_y,
    output logic             q_revealed,
    output logic             q_flagged,
    output logic             q_bomb,
    output logic [CNT_W-1:0] q_count,
    output logic [63:0]      revealed_map,
    output logic [63:0]      flag_map,
    output logic [6:0]       revealed_total,
    output logic             busy,
    output logic             game_over,
    output logic             game_won
);

    state_t           state;
    logic [CELLS-1:0] bombs;
    logic [CNT_W-1:0] cnt [CELLS];
    logic [6:0]       bomb_pop;
    logic [IDX_W-1:0] idx;
    logic             changed;
    logic [CELLS-1:0] zero_map, scan_map, nbr, loss_map;
    logic [IDX_W-1:0] sel_idx, q_idx;
    logic             sel_ok, win, sweep_hit;

    always_comb begin
        zero_map = '0;
        for (int i = 0; i < CELLS; i++)
            zero_map[i] = cnt[i] == '0;
    end

    // One scanner serves both phases: bomb neighbours while loading, revealed zero cells while sweeping.
    assign scan_map  = state == LOAD ? bombs : revealed_map & zero_map;
    assign sweep_hit = !revealed_map[idx] && !flag_map[idx] && !bombs[idx] && |nbr;
    assign win       = revealed_total == 7'(CELLS) - bomb_pop;
    assign sel_ok    = !sel_x[3] && !sel_y[3];
    assign sel_idx   = cell_idx(sel_x[2:0], sel_y[2:0]);
    assign q_idx     = cell_idx(q_x, q_y);
    assign busy      = state == LOAD || state == SWEEP;

`ifdef REVEAL_BOMBS_ON_LOSS_EN
    assign loss_map = bombs;
`else
    assign loss_map = '0;
`endif

    neighbor_scan u_scan (
        .map(scan_map),
        .idx(idx),
        .nbr(nbr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bombs          <= '0;
            bomb_pop       <= '0;
            idx            <= '0;
            changed        <= 1'b0;
            revealed_map   <= '0;
            flag_map       <= '0;
            revealed_total <= '0;
            game_over      <= 1'b0;
            game_won       <= 1'b0;
            for (int i = 0; i < CELLS; i++)
                cnt[i] <= '0;
        end else if (board_load && !busy) begin
            state          <= LOAD;
            bombs          <= cell_matrix;
            bomb_pop       <= '0;
            idx            <= '0;
            revealed_map   <= '0;
            flag_map       <= '0;
            revealed_total <= '0;
            game_over      <= 1'b0;
            game_won       <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    cnt[idx] <= CNT_W'($countones(nbr));
                    bomb_pop <= bomb_pop + 7'(bombs[idx]);
                    idx      <= idx + 1'b1;
                    if (idx == IDX_W'(CELLS - 1))
                        state <= READY;
                end
                READY, SWEEP: begin
                    if (win) begin
                        game_won <= 1'b1;
                        state    <= WON;
                    end else if (state == READY) begin
                        if (reveal_req) begin
                            if (sel_ok && !flag_map[sel_idx] && !revealed_map[sel_idx]) begin
                                if (bombs[sel_idx]) begin
                                    revealed_map <= revealed_map | loss_map | (CELLS'(1) << sel_idx);
                                    game_over    <= 1'b1;
                                    state        <= LOST;
                                end else begin
                                    revealed_map[sel_idx] <= 1'b1;
                                    revealed_total        <= revealed_total + 7'd1;
                                    if (cnt[sel_idx] == '0) begin
                                        state   <= SWEEP;
                                        idx     <= '0;
                                        changed <= 1'b0;
                                    end
                                end
                            end
                        end else if (flag_req && sel_ok && !revealed_map[sel_idx])
                            flag_map[sel_idx] <= !flag_map[sel_idx];
                    end else begin
                        if (sweep_hit) begin
                            revealed_map[idx] <= 1'b1;
                            revealed_total    <= revealed_total + 7'd1;
                        end
                        // A pass that revealed anything (including this last cell) triggers another pass.
                        if (idx == IDX_W'(CELLS - 1)) begin
                            if (changed || sweep_hit)
                                changed <= 1'b0;
                            else
                                state <= READY;
                        end else if (sweep_hit)
                            changed <= 1'b1;
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q_revealed = revealed_map[q_idx];
    assign q_flagged  = flag_map[q_idx];
    assign q_bomb     = bombs[q_idx];
    assign q_count    = cnt[q_idx];

endmodule

// File: tb/tb_cell_reveal_engine.sv
// tb_cell_reveal_engine: directed and randomized checks of the reveal engine against a rule-level model
module tb_cell_reveal_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        board_load = 1'b0;
    logic [63:0] cell_matrix = '0;
    logic [3:0]  sel_x = '0;
    logic [3:0]  sel_y = '0;
    logic        reveal_req = 1'b0;
    logic        flag_req = 1'b0;
    logic [2:0]  q_x = '0;
    logic [2:0]  q_y = '0;
    logic        q_revealed, q_flagged, q_bomb;
    logic [3:0]  q_count;
    logic [63:0] revealed_map, flag_map;
    logic [6:0]  revealed_total;
    logic        busy, game_over, game_won;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cell_reveal_engine dut (
        .clk(clk),
        .reset(reset),
        .board_load(board_load),
        .cell_matrix(cell_matrix),
        .sel_x(sel_x),
        .sel_y(sel_y),
        .reveal_req(reveal_req),
        .flag_req(flag_req),
        .q_x(q_x),
        .q_y(q_y),
        .q_revealed(q_revealed),
        .q_flagged(q_flagged),
        .q_bomb(q_bomb),
        .q_count(q_count),
        .revealed_map(revealed_map),
        .flag_map(flag_map),
        .revealed_total(revealed_total),
        .busy(busy),
        .game_over(game_over),
        .game_won(game_won)
    );

    // Reference model: game rules applied directly to whole-board bit vectors.
    logic [63:0] mb, mr, mf;
    int          mc [64];
    bit          mo, mw;

    function automatic bit in_nb(input int i, input int j);
        int dx = (i % 8) - (j % 8);
        int dy = (i / 8) - (j / 8);
        return i != j && dx >= -1 && dx <= 1 && dy >= -1 && dy <= 1;
    endfunction

    function automatic int m_safe_rev();
        int n = 0;
        for (int i = 0; i < 64; i++)
            if (mr[i] && !mb[i]) n++;
        return n;
    endfunction

    task automatic m_win();
        if (!mo && m_safe_rev() == 64 - $countones(mb)) mw = 1;
    endtask

    task automatic m_load(input logic [63:0] m);
        mb = m; mr = '0; mf = '0; mo = 0; mw = 0;
        for (int i = 0; i < 64; i++) begin
            mc[i] = 0;
            for (int j = 0; j < 64; j++)
                if (in_nb(i, j) && mb[j]) mc[i]++;
        end
        m_win();
    endtask

    task automatic m_flood();
        bit ch;
        do begin
            ch = 0;
            for (int i = 0; i < 64; i++)
                if (!mr[i] && !mf[i] && !mb[i])
                    for (int j = 0; j < 64; j++)
                        if (!mr[i] && in_nb(i, j) && mr[j] && mc[j] == 0) begin
                            mr[i] = 1;
                            ch = 1;
                        end
        end while (ch);
    endtask

    task automatic m_reveal(input int x, input int y);
        int i = y * 8 + x;
        if (mo || mw || x >= 8 || y >= 8) return;
        if (mf[i] || mr[i]) return;
        mr[i] = 1;
        if (mb[i]) begin
            mo = 1;
`ifdef REVEAL_BOMBS_ON_LOSS_EN
            mr = mr | mb;
`endif
            return;
        end
        if (mc[i] == 0) m_flood();
        m_win();
    endtask

    task automatic m_flag(input int x, input int y);
        int i = y * 8 + x;
        if (mo || mw || x >= 8 || y >= 8) return;
        if (!mr[i]) mf[i] = !mf[i];
    endtask

    // Stimulus helpers.
    task automatic settle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL settle: busy=%b after %0d cycles, required 0", busy, n);
        end
        @(negedge clk);
    endtask

    task automatic load(input logic [63:0] m);
        @(negedge clk);
        cell_matrix = m;
        board_load = 1;
        @(negedge clk);
        board_load = 0;
        settle();
        m_load(m);
    endtask

    task automatic op(input bit rv, input bit fl, input int x, input int y);
        @(negedge clk);
        sel_x = 4'(x);
        sel_y = 4'(y);
        reveal_req = rv;
        flag_req = fl;
        @(negedge clk);
        reveal_req = 0;
        flag_req = 0;
        settle();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if (revealed_map !== '0 || flag_map !== '0 || revealed_total !== '0 || busy !== 0 || game_over !== 0 || game_won !== 0) begin
            fails++;
            $display("FAIL reset: rev=%h flag=%h tot=%0d busy=%b over=%b won=%b, required all 0",
                     revealed_map, flag_map, revealed_total, busy, game_over, game_won);
        end
        reset = 0;
    endtask

    task automatic test_load();
        int n = 0;
        @(negedge clk);
        cell_matrix = 64'h1;
        board_load = 1;
        @(negedge clk);
        board_load = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        m_load(64'h1);
        tests++;
        if (n != 64) begin
            fails++;
            $display("FAIL load_busy: busy cycles %0d, required 64", n);
        end
        q_x = 1; q_y = 1; #1;
        tests++;
        if (q_count !== 4'd1) begin fails++; $display("FAIL count_1_1: got %0d, required 1", q_count); end
        q_x = 0; q_y = 1; #1;
        tests++;
        if (q_count !== 4'd1) begin fails++; $display("FAIL count_0_1: got %0d, required 1", q_count); end
        q_x = 2; q_y = 2; #1;
        tests++;
        if (q_count !== 4'd0) begin fails++; $display("FAIL count_2_2: got %0d, required 0", q_count); end
        q_x = 0; q_y = 0; #1;
        tests++;
        if (q_bomb !== 1'b1) begin fails++; $display("FAIL bomb_0_0: got %b, required 1", q_bomb); end
    endtask

    task automatic test_flood();
        op(1, 0, 7, 7);
        tests++;
        if (revealed_total !== 7'd63 || game_won !== 1 || revealed_map[0] !== 0 || revealed_map !== ~64'h1) begin
            fails++;
            $display("FAIL flood: tot=%0d won=%b rev=%h, required tot=63 won=1 rev=%h",
                     revealed_total, game_won, revealed_map, ~64'h1);
        end
    endtask

    task automatic test_loss();
        logic [63:0] exp_rev;
        load(64'h0000_0000_1800_0000);
        op(1, 0, 3, 3);
`ifdef REVEAL_BOMBS_ON_LOSS_EN
        exp_rev = 64'h0000_0000_1800_0000;
`else
        exp_rev = 64'h0000_0000_0800_0000;
`endif
        tests++;
        if (game_over !== 1 || game_won !== 0 || revealed_map !== exp_rev || revealed_total !== 0) begin
            fails++;
            $display("FAIL loss: over=%b won=%b rev=%h tot=%0d, required over=1 won=0 rev=%h tot=0",
                     game_over, game_won, revealed_map, revealed_total, exp_rev);
        end
        op(1, 0, 0, 0);
        tests++;
        if (revealed_map !== exp_rev || revealed_total !== 0) begin
            fails++;
            $display("FAIL loss_hold: rev=%h tot=%0d, required rev=%h tot=0", revealed_map, revealed_total, exp_rev);
        end
    endtask

    task automatic test_flag();
        load(64'h0000_0000_1800_0000);
        op(0, 1, 2, 2);
        op(1, 0, 2, 2);
        tests++;
        if (revealed_map[18] !== 0 || flag_map !== 64'h4_0000) begin
            fails++;
            $display("FAIL flagged_reveal: rev18=%b flag=%h, required rev18=0 flag=40000", revealed_map[18], flag_map);
        end
        op(0, 1, 2, 2);
        op(1, 0, 2, 2);
        q_x = 2; q_y = 2; #1;
        tests++;
        if (flag_map !== '0 || revealed_map !== 64'h4_0000 || q_count !== 4'd1 || revealed_total !== 7'd1) begin
            fails++;
            $display("FAIL unflag_reveal: flag=%h rev=%h cnt=%0d tot=%0d, required flag=0 rev=40000 cnt=1 tot=1",
                     flag_map, revealed_map, q_count, revealed_total);
        end
        op(1, 0, 9, 2);
        op(0, 1, 9, 2);
        tests++;
        if (revealed_map !== 64'h4_0000 || flag_map !== '0 || revealed_total !== 7'd1) begin
            fails++;
            $display("FAIL out_of_range: rev=%h flag=%h tot=%0d, required rev=40000 flag=0 tot=1",
                     revealed_map, flag_map, revealed_total);
        end
    endtask

    task automatic test_drop();
        @(negedge clk);
        cell_matrix = 64'h0000_0000_1800_0000;
        board_load = 1;
        @(negedge clk);
        board_load = 0;
        sel_x = 2; sel_y = 2;
        reveal_req = 1;
        @(negedge clk);
        reveal_req = 0;
        settle();
        tests++;
        if (revealed_map !== '0 || revealed_total !== '0) begin
            fails++;
            $display("FAIL load_drop: rev=%h tot=%0d, required rev=0 tot=0", revealed_map, revealed_total);
        end
        op(1, 1, 2, 2);
        tests++;
        if (revealed_map !== 64'h4_0000 || flag_map !== '0) begin
            fails++;
            $display("FAIL reveal_flag_same: rev=%h flag=%h, required rev=40000 flag=0", revealed_map, flag_map);
        end
    endtask

    task automatic test_reset_sweep();
        load(64'h1);
        @(negedge clk);
        sel_x = 7; sel_y = 7;
        reveal_req = 1;
        @(negedge clk);
        reveal_req = 0;
        repeat (10) @(negedge clk);
        tests++;
        if (busy !== 1) begin fails++; $display("FAIL sweep_busy: busy=%b, required 1", busy); end
        reset = 1;
        @(negedge clk);
        reset = 0;
        q_x = 1; q_y = 1; #1;
        tests++;
        if (revealed_map !== '0 || flag_map !== '0 || busy !== 0 || revealed_total !== '0 || q_count !== '0 || q_bomb !== 0 || game_won !== 0) begin
            fails++;
            $display("FAIL reset_sweep: rev=%h flag=%h busy=%b tot=%0d cnt=%0d bomb=%b won=%b, required all 0",
                     revealed_map, flag_map, busy, revealed_total, q_count, q_bomb, game_won);
        end
        op(1, 0, 5, 5);
        tests++;
        if (revealed_map !== '0) begin fails++; $display("FAIL idle_drop: rev=%h, required 0", revealed_map); end
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            logic [63:0] m;
            m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if (b == 5) m = '0;
            load(m);
            for (int k = 0; k < 30; k++) begin
                int r = $urandom_range(99);
                int x = (r < 5) ? $urandom_range(15) : $urandom_range(7);
                int y = $urandom_range(7);
                bit fl = $urandom_range(99) < 20;
                op(!fl, fl, x, y);
                if (fl) m_flag(x, y); else m_reveal(x, y);
                tests++;
                if (revealed_map !== mr || flag_map !== mf || revealed_total !== 7'(m_safe_rev()) || game_over !== mo || game_won !== mw) begin
                    fails++;
                    $display("FAIL random b%0d op%0d: rev=%h flag=%h tot=%0d over=%b won=%b, required rev=%h flag=%h tot=%0d over=%b won=%b",
                             b, k, revealed_map, flag_map, revealed_total, game_over, game_won, mr, mf, m_safe_rev(), mo, mw);
                end
                q_x = 3'($urandom_range(7));
                q_y = 3'($urandom_range(7));
                #1;
                tests++;
                if (q_count !== 4'(mc[q_y*8+q_x]) || q_bomb !== mb[q_y*8+q_x] || q_revealed !== mr[q_y*8+q_x] || q_flagged !== mf[q_y*8+q_x]) begin
                    fails++;
                    $display("FAIL query b%0d (%0d,%0d): cnt=%0d bomb=%b rev=%b flag=%b, required cnt=%0d bomb=%b rev=%b flag=%b",
                             b, q_x, q_y, q_count, q_bomb, q_revealed, q_flagged,
                             mc[q_y*8+q_x], mb[q_y*8+q_x], mr[q_y*8+q_x], mf[q_y*8+q_x]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_flood();
        test_loss();
        test_flag();
        test_drop();
        test_reset_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
